// File: rtl/axis_output_manager.sv
// Result-transfer sequencer: turns data/notification requests into a header, a send_header trigger
// and stable auto-read parameters, then tracks completion with a watchdog.
module axis_output_manager #(
  parameter int                   NUM_OUT_BRAM   = 8,
  parameter int                   BRAM_DEPTH     = 512,
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        compute_done,
  input  logic        notify_req,
  input  logic [7:0]  layer_id,
  input  logic [3:0]  out_bram_count,
  input  logic [15:0] out_addr_count,
  input  logic [15:0] status_code,
  input  logic        read_done,
  input  logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        m_axis_tlast,
  input  logic        clear_errors,
  output logic [15:0] header_word_0,
  output logic [15:0] header_word_1,
  output logic [15:0] header_word_2,
  output logic [15:0] header_word_3,
  output logic [15:0] header_word_4,
  output logic [15:0] header_word_5,
  output logic        send_header,
  output logic        notification_only,
  output logic [2:0]  rd_bram_end,
  output logic [15:0] rd_addr_count,
  output logic        busy,
  output logic        transfer_done,
  output logic        xfer_aborted,
  output logic [15:0] seq_num,
  output logic        err_bad_param,
  output logic        err_overflow,
  output logic        err_timeout
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_DATA, WAIT_NOTIFY, DONE, GAP} state_t;

  localparam logic [3:0]           MAX_BRAM  = 4'(NUM_OUT_BRAM);
  localparam logic [15:0]          MAX_DEPTH = 16'(BRAM_DEPTH);
  localparam logic [TIMEOUT_W-1:0] WD_LAST   = TIMEOUT_CYCLES - 1'b1;

  state_t state, state_nxt;
  logic   d_pend, n_pend;
  logic [7:0]  d_layer_q, n_layer_q;
  logic [3:0]  d_cnt_q;
  logic [15:0] d_addr_q, n_status_q;
  logic [TIMEOUT_W-1:0] wd_cnt;

  logic params_ok, d_live, bad_req, idle, in_wait, aborted;
  logic use_data, use_note, d_cons, d_direct, n_cons, n_direct;
  logic d_store, d_ovf, n_store, n_ovf;
  logic [7:0]  d_layer_sel, n_layer_sel;
  logic [3:0]  d_cnt_sel;
  logic [15:0] d_addr_sel, n_status_sel;
  logic [19:0] prod;

  // Request arbitration: pending slot beats live input, data beats notification.
  assign params_ok = (out_bram_count != 4'd0) && (out_bram_count <= MAX_BRAM) &&
                     (out_addr_count != 16'd0) && (out_addr_count <= MAX_DEPTH);
  assign d_live   = compute_done & params_ok;
  assign bad_req  = compute_done & ~params_ok;
  assign idle     = (state == IDLE);
  assign in_wait  = (state == WAIT_DATA) || (state == WAIT_NOTIFY);
  assign use_data = idle & (d_pend | d_live);
  assign use_note = idle & ~(d_pend | d_live) & (n_pend | notify_req);
  assign d_cons   = idle & d_pend;
  assign d_direct = idle & ~d_pend & d_live;
  assign n_cons   = use_note & n_pend;
  assign n_direct = use_note & ~n_pend & notify_req;
  assign d_store  = d_live & ~d_direct & (~d_pend | d_cons);
  assign d_ovf    = d_live & ~d_direct & d_pend & ~d_cons;
  assign n_store  = notify_req & ~n_direct & (~n_pend | n_cons);
  assign n_ovf    = notify_req & ~n_direct & n_pend & ~n_cons;

  assign d_layer_sel  = d_pend ? d_layer_q  : layer_id;
  assign d_cnt_sel    = d_pend ? d_cnt_q    : out_bram_count;
  assign d_addr_sel   = d_pend ? d_addr_q   : out_addr_count;
  assign n_layer_sel  = n_pend ? n_layer_q  : layer_id;
  assign n_status_sel = n_pend ? n_status_q : status_code;
  assign prod         = 20'(d_cnt_sel) * 20'(d_addr_sel);

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (use_data | use_note) state_nxt = ARM;
      ARM:         state_nxt = notification_only ? WAIT_NOTIFY : WAIT_DATA;
      WAIT_DATA:   if (read_done) state_nxt = DONE;
                   else if (wd_cnt == WD_LAST) state_nxt = GAP;
      WAIT_NOTIFY: if (m_axis_tvalid & m_axis_tready & m_axis_tlast) state_nxt = DONE;
                   else if (wd_cnt == WD_LAST) state_nxt = GAP;
      DONE:        state_nxt = GAP;
      GAP:         state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    send_header   = (state == ARM);
    transfer_done = (state == DONE);
    busy          = (state != IDLE);
  end

  assign aborted = in_wait && (state_nxt == GAP);

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      d_pend <= 1'b0; d_layer_q <= '0; d_cnt_q <= '0; d_addr_q <= '0;
      n_pend <= 1'b0; n_layer_q <= '0; n_status_q <= '0;
    end else begin
      if (d_store) begin
        d_pend <= 1'b1; d_layer_q <= layer_id; d_cnt_q <= out_bram_count; d_addr_q <= out_addr_count;
      end else if (d_cons) d_pend <= 1'b0;
      if (n_store) begin
        n_pend <= 1'b1; n_layer_q <= layer_id; n_status_q <= status_code;
      end else if (n_cons) n_pend <= 1'b0;
    end

  // Header and read parameters latch on the IDLE->ARM step and hold until the next launch.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      header_word_0 <= '0; header_word_1 <= '0; header_word_2 <= '0;
      header_word_3 <= '0; header_word_4 <= '0; header_word_5 <= '0;
      rd_bram_end <= '0; rd_addr_count <= '0; notification_only <= 1'b0;
    end else if (use_data) begin
      header_word_0 <= 16'hC0DE;           header_word_1 <= {8'h01, d_layer_sel};
      header_word_2 <= seq_num;            header_word_3 <= {12'd0, d_cnt_sel};
      header_word_4 <= d_addr_sel;         header_word_5 <= prod[15:0];
      rd_bram_end   <= 3'(d_cnt_sel - 4'd1);
      rd_addr_count <= d_addr_sel;         notification_only <= 1'b0;
    end else if (use_note) begin
      header_word_0 <= 16'hC0DE;           header_word_1 <= {8'h02, n_layer_sel};
      header_word_2 <= seq_num;            header_word_3 <= '0;
      header_word_4 <= '0;                 header_word_5 <= n_status_sel;
      rd_bram_end   <= '0;                 rd_addr_count <= '0;
      notification_only <= 1'b1;
    end else if (state_nxt == GAP) notification_only <= 1'b0;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      wd_cnt <= '0; seq_num <= '0; xfer_aborted <= 1'b0;
      err_bad_param <= 1'b0; err_overflow <= 1'b0; err_timeout <= 1'b0;
    end else begin
      wd_cnt       <= in_wait ? wd_cnt + 1'b1 : '0;
      xfer_aborted <= aborted;
      if (state == DONE) seq_num <= seq_num + 16'd1;
      // A new error in the same cycle as clear_errors stays set.
      err_bad_param <= bad_req         | (err_bad_param & ~clear_errors);
      err_overflow  <= (d_ovf | n_ovf) | (err_overflow  & ~clear_errors);
      err_timeout   <= aborted         | (err_timeout   & ~clear_errors);
    end
endmodule

// File: tb/tb_axis_output_manager.sv
// Randomised bench for axis_output_manager against a transaction-level header/sequence model.
module tb_axis_output_manager;
  localparam int TO = 16;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic compute_done = 0, notify_req = 0, read_done = 0, clear_errors = 0;
  logic m_axis_tvalid = 0, m_axis_tready = 0, m_axis_tlast = 0;
  logic [7:0]  layer_id = '0;
  logic [3:0]  out_bram_count = '0;
  logic [15:0] out_addr_count = '0, status_code = '0;
  logic [15:0] header_word_0, header_word_1, header_word_2, header_word_3, header_word_4, header_word_5;
  logic        send_header, notification_only, busy, transfer_done, xfer_aborted;
  logic [2:0]  rd_bram_end;
  logic [15:0] rd_addr_count, seq_num;
  logic        err_bad_param, err_overflow, err_timeout;

  axis_output_manager #(.NUM_OUT_BRAM(8), .BRAM_DEPTH(512), .TIMEOUT_W(24), .TIMEOUT_CYCLES(24'(TO))) dut (
    .aclk(aclk), .aresetn(aresetn), .compute_done(compute_done), .notify_req(notify_req),
    .layer_id(layer_id), .out_bram_count(out_bram_count), .out_addr_count(out_addr_count),
    .status_code(status_code), .read_done(read_done), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .clear_errors(clear_errors),
    .header_word_0(header_word_0), .header_word_1(header_word_1), .header_word_2(header_word_2),
    .header_word_3(header_word_3), .header_word_4(header_word_4), .header_word_5(header_word_5),
    .send_header(send_header), .notification_only(notification_only), .rd_bram_end(rd_bram_end),
    .rd_addr_count(rd_addr_count), .busy(busy), .transfer_done(transfer_done),
    .xfer_aborted(xfer_aborted), .seq_num(seq_num), .err_bad_param(err_bad_param),
    .err_overflow(err_overflow), .err_timeout(err_timeout));

  always #5 aclk = ~aclk;

  int checks = 0, failures = 0;
  logic [15:0] exp_seq = '0;

  typedef struct {
    bit          notif;
    logic [7:0]  layer;
    logic [3:0]  cnt;
    logic [15:0] addr;
    logic [15:0] status;
  } req_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick; @(negedge aclk); endtask

  function automatic req_t rnd_data();
    req_t r;
    r.notif = 0; r.layer = 8'($urandom); r.cnt = 4'($urandom_range(1, 8));
    r.addr = 16'($urandom_range(1, 512)); r.status = '0;
    return r;
  endfunction

  function automatic req_t rnd_note();
    req_t r;
    r.notif = 1; r.layer = 8'($urandom); r.cnt = '0; r.addr = '0; r.status = 16'($urandom);
    return r;
  endfunction

  task automatic drive(input req_t r);
    layer_id = r.layer;
    if (r.notif) begin notify_req = 1; status_code = r.status; end
    else begin compute_done = 1; out_bram_count = r.cnt; out_addr_count = r.addr; end
  endtask

  task automatic idle_in; compute_done = 0; notify_req = 0; endtask

  // Called in the ARM cycle; returns in the first wait cycle.
  task automatic arm_check(input req_t r);
    int p;
    p = int'(r.cnt) * int'(r.addr);
    chk("send_header", 32'(send_header), 1);
    chk("w0", 32'(header_word_0), 32'h0000C0DE);
    chk("w1", 32'(header_word_1), 32'({(r.notif ? 8'h02 : 8'h01), r.layer}));
    chk("w2", 32'(header_word_2), 32'(exp_seq));
    chk("w3", 32'(header_word_3), r.notif ? 0 : 32'(r.cnt));
    chk("w4", 32'(header_word_4), r.notif ? 0 : 32'(r.addr));
    chk("w5", 32'(header_word_5), r.notif ? 32'(r.status) : (p & 32'hFFFF));
    chk("rd_bram_end", 32'(rd_bram_end), r.notif ? 0 : 32'(r.cnt - 4'd1));
    chk("rd_addr_count", 32'(rd_addr_count), r.notif ? 0 : 32'(r.addr));
    chk("notif_arm", 32'(notification_only), 32'(r.notif));
    tick;
    chk("sh_once", 32'(send_header), 0);
    chk("busy_wait", 32'(busy), 1);
    chk("notif_wait", 32'(notification_only), 32'(r.notif));
  endtask

  // Starts in a wait cycle, injects ignorable events, then completes; returns in the first IDLE cycle.
  task automatic complete(input req_t r, input int dly);
    if (r.notif) read_done = 1;
    else begin m_axis_tvalid = 1; m_axis_tready = 1; m_axis_tlast = 1; end
    tick; read_done = 0; m_axis_tlast = 0;
    tick; m_axis_tready = 0; m_axis_tlast = 1;
    tick; m_axis_tvalid = 0; m_axis_tlast = 0;
    repeat (dly) tick;
    chk("no_early_done", 32'(transfer_done), 0);
    chk("busy_before_done", 32'(busy), 1);
    if (r.notif) begin m_axis_tvalid = 1; m_axis_tready = 1; m_axis_tlast = 1; end
    else read_done = 1;
    tick; read_done = 0; m_axis_tvalid = 0; m_axis_tready = 0; m_axis_tlast = 0;
    chk("transfer_done", 32'(transfer_done), 1);
    tick;
    exp_seq = exp_seq + 16'd1;
    chk("seq_num", 32'(seq_num), 32'(exp_seq));
    chk("gap_notif", 32'(notification_only), 0);
    chk("gap_busy", 32'(busy), 1);
    chk("done_once", 32'(transfer_done), 0);
    tick;
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic count_sh(input string tag, input int n);
    int s = 0;
    repeat (n) begin tick; s += int'(send_header); end
    chk(tag, 32'(s), 0);
  endtask

  initial begin
    req_t r, r2, r3;
    int w;
    #1;
    tick;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_seq", 32'(seq_num), 0);
    chk("rst_w0", 32'(header_word_0), 0);
    chk("rst_errs", 32'({err_bad_param, err_overflow, err_timeout}), 0);
    aresetn = 1;
    tick;

    // Full-size data transfer
    r.notif = 0; r.layer = 8'd3; r.cnt = 4'd8; r.addr = 16'd512; r.status = '0;
    drive(r); tick; idle_in;
    arm_check(r); complete(r, 2);

    // Fixed notification
    r = rnd_note(); r.status = 16'h00AA;
    drive(r); tick; idle_in;
    arm_check(r); complete(r, 1);

    for (int i = 0; i < 8; i++) begin
      r = ($urandom_range(0, 1) == 0) ? rnd_data() : rnd_note();
      if (i == 2) begin r = rnd_data(); r.cnt = 4'd1; r.addr = 16'd1; end
      drive(r); tick; idle_in;
      arm_check(r); complete(r, $urandom_range(0, 8));
      repeat ($urandom_range(0, 3)) tick;
    end

    // Simultaneous data and notification: data first, notification from its slot
    r = rnd_data(); r2 = rnd_note(); r2.layer = r.layer;
    drive(r); drive(r2); tick; idle_in;
    arm_check(r); complete(r, 3);
    tick; arm_check(r2); complete(r2, 1);

    // Two requests while busy: one queued, one dropped
    r = rnd_data(); r2 = rnd_data(); r3 = rnd_data();
    drive(r); tick; idle_in;
    arm_check(r);
    drive(r2); tick; idle_in;
    drive(r3); tick; idle_in;
    chk("overflow_set", 32'(err_overflow), 1);
    complete(r, 0);
    tick; arm_check(r2); complete(r2, 2);
    count_sh("no_third_xfer", 8);
    clear_errors = 1; tick; clear_errors = 0;
    chk("overflow_clr", 32'(err_overflow), 0);

    // Each bad-parameter class is rejected
    for (int k = 0; k < 4; k++) begin
      r = rnd_data();
      case (k)
        0: r.cnt = 4'd0;
        1: r.cnt = 4'($urandom_range(9, 15));
        2: r.addr = 16'd0;
        default: r.addr = 16'($urandom_range(513, 65535));
      endcase
      drive(r); tick; idle_in;
      chk("bad_no_busy", 32'(busy), 0);
      chk("bad_no_sh", 32'(send_header), 0);
      chk("bad_param_set", 32'(err_bad_param), 1);
      if (k == 3) begin
        drive(r); clear_errors = 1; tick; idle_in; clear_errors = 0;
        chk("bad_set_wins", 32'(err_bad_param), 1);
      end
      clear_errors = 1; tick; clear_errors = 0;
      chk("bad_param_clr", 32'(err_bad_param), 0);
    end

    // Watchdog abort
    r = rnd_data();
    drive(r); tick; idle_in;
    arm_check(r);
    w = 0;
    while (!xfer_aborted && w < 40) begin tick; w++; end
    chk("timeout_cycles", 32'(w), 32'(TO));
    chk("err_timeout", 32'(err_timeout), 1);
    chk("seq_after_abort", 32'(seq_num), 32'(exp_seq));
    chk("abort_busy_gap", 32'(busy), 1);
    tick;
    chk("abort_once", 32'(xfer_aborted), 0);
    chk("abort_idle", 32'(busy), 0);

    // Asynchronous reset mid-wait with a request queued
    r = rnd_data(); r2 = rnd_data();
    drive(r); tick; idle_in;
    arm_check(r);
    drive(r2); tick; idle_in;
    #2 aresetn = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_w0", 32'(header_word_0), 0);
    chk("arst_w1", 32'(header_word_1), 0);
    chk("arst_rd_addr", 32'(rd_addr_count), 0);
    chk("arst_seq", 32'(seq_num), 0);
    chk("arst_err", 32'(err_timeout), 0);
    tick; aresetn = 1;
    count_sh("arst_pend_drop", 8);
    chk("arst_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
